// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns a single-ended PWM stream into a complementary
// high-side / low-side gate pair with a programmable dead-time gap at every
// edge. Pulses shorter than the dead-time are swallowed and flagged.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                pwm_in,
    output logic                pwm_hi,
    output logic                pwm_lo,
    output logic                pulse_dropped
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO      = 3'd1,
        S_HI      = 3'd2,
        S_DT_RISE = 3'd3,
        S_DT_FALL = 3'd4
    } state_t;

    localparam logic [DT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [DT_WIDTH-1:0] CNT_ONE  = DT_WIDTH'(1);

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                pwm_q;
    logic                drop_d;
    logic                hi_d, lo_d;
    logic                hi_q, lo_q, drop_q;

    // State, counter, input sample and registered gate drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            pwm_q   <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_in;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; disabling the bridge overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Leaving IDLE always inserts a full gap before any gate turns on.
                    if (dead_time == CNT_ZERO) begin
                        state_d = pwm_q ? S_HI : S_LO;
                    end else begin
                        state_d = pwm_q ? S_DT_RISE : S_DT_FALL;
                        cnt_d   = dead_time;
                    end
                end
                S_LO: begin
                    if (pwm_q) begin
                        if (dead_time == CNT_ZERO) begin
                            state_d = S_HI;
                        end else begin
                            state_d = S_DT_RISE;
                            cnt_d   = dead_time;
                        end
                    end
                end
                S_HI: begin
                    if (!pwm_q) begin
                        if (dead_time == CNT_ZERO) begin
                            state_d = S_LO;
                        end else begin
                            state_d = S_DT_FALL;
                            cnt_d   = dead_time;
                        end
                    end
                end
                S_DT_RISE: begin
                    // Input fell back before the gap expired: the pulse is cancelled.
                    if (!pwm_q) begin
                        state_d = S_LO;
                        drop_d  = 1'b1;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = S_HI;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_DT_FALL: begin
                    if (pwm_q) begin
                        state_d = S_HI;
                        drop_d  = 1'b1;
                    end else if (cnt_q <= CNT_ONE) begin
                        state_d = S_LO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Gate drives decoded from the next state so they change on the transition edge.
    always_comb begin
        hi_d = (state_d == S_HI);
        lo_d = (state_d == S_LO);
    end

    assign pwm_hi        = hi_q;
    assign pwm_lo        = lo_q;
    assign pulse_dropped = drop_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed testbench for pwm_deadtime.
module tb_pwm_deadtime;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] dead_time;
    logic       pwm_in;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       pulse_dropped;

    int checks = 0;
    int errors = 0;

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .dead_time     (dead_time),
        .pwm_in        (pwm_in),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .pulse_dropped (pulse_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gates must never overlap, in any cycle.
    always @(negedge clk) begin
        checks++;
        assert ((pwm_hi & pwm_lo) === 1'b0) else begin
            errors++;
            $error("FAIL overlap observed hi=%0b lo=%0b expected not both 1", pwm_hi, pwm_lo);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one PWM period and count output states after each edge.
    task automatic run_period(input int n, input int h,
                              output int nh, output int nl, output int nb);
        nh = 0; nl = 0; nb = 0;
        for (int i = 0; i < n; i++) begin
            pwm_in = (i < h);
            tick();
            if (pwm_hi) nh++;
            if (pwm_lo) nl++;
            if (!pwm_hi && !pwm_lo) nb++;
        end
    endtask

    initial begin
        int nh, nl, nb, n, npd;
        bit found;

        // Reset state
        reset = 1'b1; enable = 1'b0; dead_time = 8'd5; pwm_in = 1'b0;
        tick(); tick();
        chk("rst_hi", int'(pwm_hi), 0);
        chk("rst_lo", int'(pwm_lo), 0);
        chk("rst_pd", int'(pulse_dropped), 0);

        // 100-cycle period, 50% duty, dead_time=5
        reset = 1'b0; enable = 1'b1;
        run_period(100, 50, nh, nl, nb);
        run_period(100, 50, nh, nl, nb);
        run_period(100, 50, nh, nl, nb);
        chk("dt5_hi", nh, 45);
        chk("dt5_lo", nl, 45);
        chk("dt5_both", nb, 10);

        // Same waveform with no dead-time
        dead_time = 8'd0;
        run_period(100, 50, nh, nl, nb);
        run_period(100, 50, nh, nl, nb);
        run_period(100, 50, nh, nl, nb);
        chk("dt0_hi", nh, 50);
        chk("dt0_lo", nl, 50);
        chk("dt0_both", nb, 0);

        // Latency: hi rises two edges after the pwm_in rise
        pwm_in = 1'b1;
        tick();
        chk("lat1_hi", int'(pwm_hi), 0);
        chk("lat1_lo", int'(pwm_lo), 1);
        tick();
        chk("lat2_hi", int'(pwm_hi), 1);
        chk("lat2_lo", int'(pwm_lo), 0);

        // Short 3-cycle pulse from LO with dead_time=5 is swallowed
        dead_time = 8'd5; pwm_in = 1'b0;
        repeat (10) tick();
        chk("pre_drop_lo", int'(pwm_lo), 1);
        n = 0; npd = 0;
        for (int i = 0; i < 12; i++) begin
            pwm_in = (i < 3);
            tick();
            if (pwm_hi) n++;
            if (pulse_dropped) npd++;
        end
        chk("drop_hi_cyc", n, 0);
        chk("drop_strobes", npd, 1);
        chk("drop_lo_end", int'(pwm_lo), 1);

        // Disable while in HI, then re-enable with dead_time=4
        pwm_in = 1'b1;
        repeat (10) tick();
        chk("pre_dis_hi", int'(pwm_hi), 1);
        enable = 1'b0;
        tick();
        chk("dis_hi", int'(pwm_hi), 0);
        chk("dis_lo", int'(pwm_lo), 0);
        pwm_in = 1'b0; dead_time = 8'd4;
        repeat (3) tick();
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!pwm_hi && !pwm_lo) n++;
        end
        chk("reen_gap", n, 4);
        tick();
        chk("reen_lo", int'(pwm_lo), 1);
        chk("reen_hi", int'(pwm_hi), 0);

        // Reset during DT_RISE with cnt=3
        dead_time = 8'd5; pwm_in = 1'b1;
        repeat (4) tick();
        chk("dtr_hi", int'(pwm_hi), 0);
        chk("dtr_lo", int'(pwm_lo), 0);
        reset = 1'b1; pwm_in = 1'b0;
        tick();
        chk("mrst_hi", int'(pwm_hi), 0);
        chk("mrst_lo", int'(pwm_lo), 0);
        chk("mrst_pd", int'(pulse_dropped), 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!pwm_hi && !pwm_lo) n++;
        end
        chk("post_rst_gap", n, 5);
        tick();
        chk("post_rst_lo", int'(pwm_lo), 1);

        // dead_time changed 5 -> 2 in the middle of DT_FALL
        pwm_in = 1'b1;
        repeat (10) tick();
        chk("pre_chg_hi", int'(pwm_hi), 1);
        pwm_in = 1'b0;
        tick(); tick();
        n = (!pwm_hi && !pwm_lo) ? 1 : 0;
        dead_time = 8'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!pwm_hi && !pwm_lo) n++;
        end
        chk("chg_gap_old", n, 5);
        tick();
        chk("chg_lo", int'(pwm_lo), 1);
        pwm_in = 1'b1;
        tick(); tick();
        n = (!pwm_hi && !pwm_lo) ? 1 : 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pwm_hi) found = 1'b1;
            else if (!pwm_lo) n++;
        end
        chk("chg_found_hi", int'(found), 1);
        chk("chg_gap_new", n, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
